exp_arbiter: RTL and testbench
==============================

# exp_arbiter

Round-robin arbiter and sequencer that shares one exponential-series datapath (start/ready handshake, single x operand, single result) among N requesters. It sits between the requesting units and the datapath controller. It picks one pending requester, drives the datapath's start handshake with that requester's operand, waits for completion, returns the result with a one-cycle done pulse, and then rotates priority. A watchdog aborts a grant whose datapath never completes.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- XW, 8, operand width
- RW, 16, result width
- TIMEOUT, 255, maximum cycles spent in START+RUN before abort (fits in 8-bit counter)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N  request per requester; held high until that requester sees done or err
- x_in  in  N*XW  operands, requester k at bits [k*XW +: XW]
- gnt  out  N  one-hot grant, held from grant through DONE/ERR cycle
- done  out  1  one-cycle pulse, result valid for granted requester
- err  out  1  one-cycle pulse, granted request aborted by watchdog
- result  out  RW  last completed result, held until next completion
- dp_start  out  1  datapath start
- dp_x  out  XW  datapath operand, registered at grant, stable for whole grant
- dp_ready  in  1  datapath idle/ready (high in its wait-for-start state)
- dp_result  in  RW  datapath result, valid when dp_ready high after a run

## Operation
- States: IDLE, START, RUN, DONE, ERR. Reset -> IDLE.
- Reset values: gnt=0, done=0, err=0, result=0, dp_start=0, dp_x=0, priority pointer ptr=0, watchdog count=0.
- IDLE: if any req bit high AND dp_ready==1, select first set bit scanning ptr, ptr+1, ... mod N. Register gnt=onehot(k), dp_x=x_in[k]. Set ptr=(k+1) mod N. Go to START. If dp_ready==0, no grant; stay.
- START: dp_start=1 (Moore). On dp_ready==0 go to RUN. The datapath's leave-init step needs start low, so dp_start must drop in RUN.
- RUN: dp_start=0. On dp_ready==1, capture result<=dp_result and go to DONE.
- DONE: done=1, gnt unchanged. Next -> IDLE, gnt cleared.
- ERR: err=1, gnt unchanged, result not updated. Next -> IDLE.
- Watchdog: cleared on entry to START, increments each cycle in START/RUN. When count==TIMEOUT in START or RUN, go to ERR. This takes priority over the normal transition in that cycle.
- A req dropped mid-grant is ignored. The run completes and done still pulses.
- Requests arriving during a grant wait. Arbitration uses only the req value sampled in IDLE.
- dp_x changes only at grant.

## Timing
- Outputs are registered state decodes. Req high at edge t (IDLE, dp_ready=1) gives gnt and dp_start high in cycle t+1.
- Datapath enters init (dp_ready=0) at t+2. Arbiter sees it and enters RUN at t+3, so dp_start is high exactly 2 cycles for a responsive datapath.
- If dp_ready rises in cycle c, done and the new result are visible in cycle c+1. gnt drops at c+2, and IDLE may re-grant, so a new gnt appears at c+3.
- Back-to-back minimum gap: one IDLE cycle between DONE and the next START.
- Simultaneous requests: exactly one gnt bit set ever. Round-robin guarantees each of N continuously requesting units is served within N grants.
- Reset mid-operation: next cycle all outputs are at reset values and the state is IDLE. It re-grants only once dp_ready==1, because the datapath is reset with the same rst.
- Watchdog: stuck datapath yields err in cycle t+1+TIMEOUT+1 after grant.

## Test plan
- Single request: req=0010, x_in[1]=8'h05, model datapath runs 70 cycles then returns 16'h1234 -> gnt=0010, dp_x=05, dp_start high 2 cycles, done pulse, result=1234, gnt clears.
- Round-robin: req=1111 held, each run returns k -> grants in order 0,1,2,3,0. ptr wraps at N-1; gnt always one-hot.
- Priority rotation with gaps: ptr=2 (after grant 1), req=0011 -> grant 0, not 1; next req=0010 -> grant 1.
- Timeout: TIMEOUT=20, datapath holds dp_ready=0 forever -> err pulse at cycle 22 after grant. result unchanged, no done, no new grant while dp_ready=0.
- Reset mid-RUN: assert rst 1 cycle during RUN -> next cycle gnt=0, done=0, dp_start=0, result=0. A pending req is granted once dp_ready returns high.
- Req dropped mid-grant: req=0100 deasserted during RUN -> run completes, done pulses with gnt=0100, then IDLE with no re-grant.

Source files
------------

// File: rtl/exp_arbiter.sv
// Round-robin arbiter/sequencer sharing one exponential-series datapath
// among N requesters, with a watchdog that aborts a stuck run.
module exp_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned XW      = 8,
  parameter int unsigned RW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*XW-1:0] x_in,
  output logic [N-1:0]    gnt,
  output logic            done,
  output logic            err,
  output logic [RW-1:0]   result,
  output logic            dp_start,
  output logic [XW-1:0]   dp_x,
  input  logic            dp_ready,
  input  logic [RW-1:0]   dp_result
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW = PW + 1;
  localparam int unsigned WW = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [WW-1:0] wd;
  logic [WW-1:0] wd_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [XW-1:0] dp_x_nxt;
  logic [RW-1:0] result_nxt;

  logic          pick_vld_c;
  logic [PW-1:0] pick_c;
  logic [IW-1:0] idx_c;
  logic [XW-1:0] pick_x_c;

  // First pending request scanning upward from ptr, wrapping at N
  always_comb begin
    pick_vld_c = 1'b0;
    pick_c     = '0;
    idx_c      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx_c = IW'(ptr) + IW'(i);
      if (idx_c >= IW'(N)) begin
        idx_c = idx_c - IW'(N);
      end
      if (!pick_vld_c && req[PW'(idx_c)]) begin
        pick_vld_c = 1'b1;
        pick_c     = PW'(idx_c);
      end
    end
  end

  // Operand lane of the selected requester
  always_comb begin
    pick_x_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (PW'(i) == pick_c) begin
        pick_x_c = x_in[i*XW +: XW];
      end
    end
  end

  // Next-state and next-register values; watchdog overrides the normal exit
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    wd_nxt     = wd;
    gnt_nxt    = gnt;
    dp_x_nxt   = dp_x;
    result_nxt = result;
    case (state)
      S_IDLE: begin
        if (pick_vld_c && dp_ready) begin
          state_nxt = S_START;
          gnt_nxt   = N'(1) << pick_c;
          dp_x_nxt  = pick_x_c;
          ptr_nxt   = (32'(pick_c) == N - 1) ? '0 : PW'(pick_c + 1'b1);
          wd_nxt    = '0;
        end
      end
      S_START, S_RUN: begin
        if (wd == WW'(TIMEOUT)) begin
          state_nxt = S_ERR;
        end else begin
          wd_nxt = wd + 1'b1;
          if (state == S_START && !dp_ready) begin
            state_nxt = S_RUN;
          end else if (state == S_RUN && dp_ready) begin
            state_nxt  = S_DONE;
            result_nxt = dp_result;
          end
        end
      end
      S_DONE, S_ERR: begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State, datapath-side registers and registered state decodes
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      wd       <= '0;
      gnt      <= '0;
      dp_x     <= '0;
      result   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      dp_start <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      wd       <= wd_nxt;
      gnt      <= gnt_nxt;
      dp_x     <= dp_x_nxt;
      result   <= result_nxt;
      done     <= (state_nxt == S_DONE);
      err      <= (state_nxt == S_ERR);
      dp_start <= (state_nxt == S_START);
    end
  end

endmodule

// File: tb/tb_exp_arbiter.sv
// Bench for exp_arbiter: directed tables, hand sequences, and a random
// phase checked cycle by cycle against a behavioural reference model.
module tb_exp_arbiter;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int RW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*XW-1:0] x_in = '0;
  logic [N-1:0]    gnt;
  logic            done, err, dp_start;
  logic [RW-1:0]   result;
  logic [XW-1:0]   dp_x;
  logic            dp_ready = 1'b1;
  logic [RW-1:0]   dp_result = '0;

  // second instance with a short watchdog, datapath driven by hand
  logic [N-1:0]    req2 = '0;
  logic [N*XW-1:0] x2 = '0;
  logic            rdy2 = 1'b1;
  logic [RW-1:0]   res2 = '0;
  logic [N-1:0]    gnt2;
  logic            done2, err2, start2;
  logic [RW-1:0]   result2;
  logic [XW-1:0]   dpx2;

  int nvec = 0;
  int nerr = 0;

  exp_arbiter #(.N(N), .XW(XW), .RW(RW), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .gnt(gnt), .done(done),
    .err(err), .result(result), .dp_start(dp_start), .dp_x(dp_x),
    .dp_ready(dp_ready), .dp_result(dp_result));

  exp_arbiter #(.N(N), .XW(XW), .RW(RW), .TIMEOUT(20)) dut_wd (
    .clk(clk), .rst(rst), .req(req2), .x_in(x2), .gnt(gnt2), .done(done2),
    .err(err2), .result(result2), .dp_start(start2), .dp_x(dpx2),
    .dp_ready(rdy2), .dp_result(res2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [RW-1:0] res_fn(input logic [XW-1:0] x);
    return {x ^ 8'h5A, x};
  endfunction

  // ---------------- behavioural datapath ----------------
  int            dp_lat = 4;
  bit            dp_use_val = 1'b0;
  logic [RW-1:0] dp_val = '0;
  int            dps = 0;
  int            dcnt = 0;
  logic [XW-1:0] lat_x = '0;

  always @(posedge clk) begin
    if (rst) begin
      dps <= 0;
      dp_ready <= 1'b1;
      dcnt <= 0;
    end else begin
      case (dps)
        0: if (dp_start) begin dps <= 1; dp_ready <= 1'b0; lat_x <= dp_x; end
        1: if (!dp_start) begin dps <= 2; dcnt <= dp_lat; end
        default: begin
          if (dcnt <= 1) begin
            dps <= 0;
            dp_ready <= 1'b1;
            dp_result <= dp_use_val ? dp_val : res_fn(lat_x);
          end else begin
            dcnt <= dcnt - 1;
          end
        end
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (p + j) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  bit              cap_valid = 1'b0;
  logic            c_rst, c_ready;
  logic [N-1:0]    c_req;
  logic [N*XW-1:0] c_x;
  logic [RW-1:0]   c_dpres;

  // inputs as the DUT samples them at the rising edge
  always @(posedge clk) begin
    c_rst   = rst;
    c_ready = dp_ready;
    c_req   = req;
    c_x     = x_in;
    c_dpres = dp_result;
    cap_valid = 1'b1;
  end

  logic [N-1:0]  m_gnt = '0;
  logic          m_start = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [XW-1:0] m_dpx = '0;
  logic [RW-1:0] m_res = '0;
  int            m_ptr = 0;

  // expected outputs derived from the timing rules, compared mid-cycle
  always @(negedge clk) begin
    logic [N-1:0]  eg;
    logic          es, ed, ee;
    logic [XW-1:0] ex;
    int k;
    if (cap_valid) begin
      eg = '0; es = 1'b0; ed = 1'b0; ee = 1'b0; ex = m_dpx;
      if (c_rst) begin
        ex = '0; m_ptr = 0; m_res = '0;
      end else if (m_gnt == '0) begin
        if (c_req != '0 && c_ready) begin
          k = rr_pick(c_req, m_ptr);
          eg = N'(1) << k;
          es = 1'b1;
          ex = c_x[k*XW +: XW];
          m_ptr = (k + 1) % N;
        end
      end else if (!(m_done || m_err)) begin
        eg = m_gnt;
        es = m_start && c_ready;
        ed = !m_start && c_ready;
        if (ed) m_res = c_dpres;
      end
      chk("m_gnt", 32'(gnt), 32'(eg));
      chk("m_start", 32'(dp_start), 32'(es));
      chk("m_done", 32'(done), 32'(ed));
      chk("m_err", 32'(err), 32'(ee));
      chk("m_dpx", 32'(dp_x), 32'(ex));
      chk("m_result", 32'(result), 32'(m_res));
      m_gnt = eg; m_start = es; m_done = ed; m_err = ee; m_dpx = ex;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_gnt();
    int n = 0;
    while (gnt == '0 && n < 300) begin cyc(); n++; end
    chk("gnt_arrives", 32'(gnt != '0), 32'd1);
  endtask

  task automatic wait_done(input bit drop_mid, output int starts);
    int n = 0;
    starts = 0;
    while (!done && n < 400) begin
      if (dp_start) starts++;
      if (drop_mid && n == 12) req = '0;
      cyc();
      n++;
    end
    chk("done_arrives", 32'(done), 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]    r;
    logic [N*XW-1:0] x;
    int              lat;
    logic [RW-1:0]   val;
    logic [N-1:0]    eg;
    logic [XW-1:0]   ex;
  } vec_t;

  vec_t tbl[7];

  task automatic run_one(input vec_t v, input bit drop_mid);
    int starts;
    req = v.r; x_in = v.x; dp_lat = v.lat; dp_val = v.val; dp_use_val = 1'b1;
    wait_gnt();
    chk("tbl_gnt", 32'(gnt), 32'(v.eg));
    chk("tbl_dpx", 32'(dp_x), 32'(v.ex));
    wait_done(drop_mid, starts);
    chk("tbl_start_len", 32'(starts), 32'd2);
    chk("tbl_gnt_at_done", 32'(gnt), 32'(v.eg));
    chk("tbl_result", 32'(result), 32'(v.val));
    req = '0;
    cyc();
    chk("tbl_gnt_clear", 32'(gnt), 32'd0);
  endtask

  initial begin
    int starts;
    tbl[0] = '{4'b0010, 32'h44330511, 70, 16'h1234, 4'b0010, 8'h05};
    tbl[1] = '{4'b0011, 32'h44332211,  5, 16'h0A0B, 4'b0001, 8'h11};
    tbl[2] = '{4'b0010, 32'h44332211,  3, 16'h0C0D, 4'b0010, 8'h22};
    tbl[3] = '{4'b1001, 32'h44332211,  4, 16'h1111, 4'b1000, 8'h44};
    tbl[4] = '{4'b1100, 32'h44332211,  6, 16'h2222, 4'b0100, 8'h33};
    tbl[5] = '{4'b0111, 32'h44332211,  2, 16'h3333, 4'b0001, 8'h11};
    tbl[6] = '{4'b1111, 32'h44332211,  8, 16'h4444, 4'b0010, 8'h22};

    // reset values
    repeat (3) cyc();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_start", 32'(dp_start), 32'd0);
    chk("rst_dpx", 32'(dp_x), 32'd0);
    rst = 1'b0;
    cyc();

    // round robin with all requests held: 0,1,2,3,0
    req = 4'hF; x_in = 32'h13121110; dp_use_val = 1'b0; dp_lat = 6;
    for (int g = 0; g < 5; g++) begin
      wait_gnt();
      chk("rr_gnt", 32'(gnt), 32'(1 << (g % N)));
      chk("rr_dpx", 32'(dp_x), 32'(8'h10 + g % N));
      wait_done(1'b0, starts);
      chk("rr_start_len", 32'(starts), 32'd2);
      chk("rr_result", 32'(result), 32'(res_fn(8'(8'h10 + g % N))));
      if (g == 4) req = '0;
      cyc();
      chk("rr_gnt_clear", 32'(gnt), 32'd0);
    end

    // table: priority rotation from a known pointer
    pulse_rst();
    for (int i = 0; i < 7; i++) run_one(tbl[i], 1'b0);

    // request dropped mid-run still completes, no re-grant afterwards
    run_one('{4'b0100, 32'h44332211, 40, 16'h5678, 4'b0100, 8'h33}, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("drop_no_regrant", 32'(gnt), 32'd0);
    end

    // reset in the middle of a run
    req = 4'b0100; dp_lat = 60; dp_val = 16'h9ABC;
    wait_gnt();
    repeat (8) cyc();
    chk("mid_in_run", 32'(dp_start), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_start", 32'(dp_start), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    cyc();
    chk("mid_regrant", 32'(gnt), 32'b0100);
    wait_done(1'b0, starts);
    chk("mid_result", 32'(result), 32'h9ABC);
    req = '0;
    cyc();

    // watchdog instance: one normal run, then a stuck datapath
    req2 = 4'b0001; x2 = 32'h00000077;
    cyc();
    chk("wd_gnt", 32'(gnt2), 32'b0001);
    chk("wd_start", 32'(start2), 32'd1);
    chk("wd_dpx", 32'(dpx2), 32'h77);
    rdy2 = 1'b0;
    cyc();
    chk("wd_start_drop", 32'(start2), 32'd0);
    res2 = 16'hBEEF; rdy2 = 1'b1;
    cyc();
    chk("wd_done", 32'(done2), 32'd1);
    chk("wd_result", 32'(result2), 32'hBEEF);
    req2 = '0;
    cyc();
    chk("wd_gnt_clear", 32'(gnt2), 32'd0);

    req2 = 4'b0100; x2 = 32'h00550000;
    cyc();
    chk("to_gnt", 32'(gnt2), 32'b0100);
    chk("to_dpx", 32'(dpx2), 32'h55);
    rdy2 = 1'b0;
    for (int i = 2; i <= 26; i++) begin
      cyc();
      if (i < 22) begin
        chk("to_no_err_yet", 32'(err2), 32'd0);
        chk("to_gnt_held", 32'(gnt2), 32'b0100);
      end else if (i == 22) begin
        chk("to_err", 32'(err2), 32'd1);
        chk("to_no_done", 32'(done2), 32'd0);
        chk("to_result_kept", 32'(result2), 32'hBEEF);
        chk("to_gnt_at_err", 32'(gnt2), 32'b0100);
      end else begin
        chk("to_err_pulse", 32'(err2), 32'd0);
        chk("to_no_grant_busy_dp", 32'(gnt2), 32'd0);
      end
    end
    rdy2 = 1'b1;
    cyc();
    chk("to_regrant", 32'(gnt2), 32'b0100);
    req2 = '0;

    // random traffic checked by the reference model
    dp_use_val = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (done) req = req & ~gnt;
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(3) == 0) begin
          req[k] = 1'b1;
          x_in[k*XW +: XW] = 8'($urandom);
        end
      end
      dp_lat = $urandom_range(12, 1);
      cyc();
    end
    req = '0;
    repeat (40) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
